// File: rtl/exec_pkg.sv
// Shared types and constants for the action-executor scheduler.
package exec_pkg;

    localparam int DEFAULT_ADDR_W = 8;

    localparam logic TRUE  = 1'b1;
    localparam logic FALSE = 1'b0;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_RELEASE,
        ST_MOD
    } exec_sched_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set request at or after ptr, wrapping.
module rr_arbiter #(
    parameter  int NUM_REQ = 4,
    localparam int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] gnt,
    output logic [IDX_W-1:0]   idx,
    output logic               any
);

    localparam int DBL_W     = 2 * NUM_REQ;
    localparam int DBL_IDX_W = $clog2(DBL_W);

    // Doubling the vector turns the wrapping search into a plain linear scan.
    logic [DBL_W-1:0]     dbl;
    logic [DBL_IDX_W-1:0] pos;

    assign dbl = {req, req};

    always_comb begin
        // NOTE: every output gets a default first so no path leaves a latch.
        gnt = '0;
        idx = '0;
        any = 1'b0;
        pos = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            pos = DBL_IDX_W'(ptr) + DBL_IDX_W'(i);
            if (!any && dbl[pos]) begin
                any = 1'b1;
                idx = (pos >= DBL_IDX_W'(NUM_REQ)) ? IDX_W'(pos - DBL_IDX_W'(NUM_REQ))
                                                   : IDX_W'(pos);
            end
        end
        if (any) gnt[idx] = 1'b1;
    end

endmodule

// File: rtl/exec_sched.sv
// Shares one action executor among NUM_REQ requesters, interleaving op-table
// reconfiguration; owns the executor start/ready and mod_start handshakes.
module exec_sched
    import exec_pkg::*;
#(
    parameter  int NUM_REQ = 4,
    parameter  int ADDR_W  = DEFAULT_ADDR_W,
    localparam int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [NUM_REQ-1:0]              req_i,
    input  logic [NUM_REQ-1:0][ADDR_W-1:0]  op_start_i,
    output logic [NUM_REQ-1:0]              gnt_o,
    output logic [IDX_W-1:0]                sel_o,
    output logic [NUM_REQ-1:0]              done_o,
    output logic                            exec_start_o,
    output logic [ADDR_W-1:0]               exec_op_start_o,
    input  logic                            exec_ready_i,
    input  logic                            mod_req_i,
    output logic                            mod_ack_o,
    output logic                            exec_mod_start_o,
    output logic                            busy_o
);

    exec_sched_state_t    state_q, state_d;
    logic [NUM_REQ-1:0]   gnt_q,   gnt_d;
    logic [IDX_W-1:0]     sel_q,   sel_d;
    logic [ADDR_W-1:0]    op_q,    op_d;
    logic [IDX_W-1:0]     ptr_q,   ptr_d;
    logic [NUM_REQ-1:0]   done_q,  done_d;

    logic [NUM_REQ-1:0]   arb_gnt;
    logic [IDX_W-1:0]     arb_idx;
    logic                 arb_any;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_arb (
        .req (req_i),
        .ptr (ptr_q),
        .gnt (arb_gnt),
        .idx (arb_idx),
        .any (arb_any)
    );

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        sel_d   = sel_q;
        op_d    = op_q;
        ptr_d   = ptr_q;
        done_d  = '0;
        unique case (state_q)
            ST_IDLE: begin
                if (mod_req_i == TRUE) begin
                    state_d = ST_MOD;
                end else if (arb_any) begin
                    state_d = ST_RUN;
                    gnt_d   = arb_gnt;
                    sel_d   = arb_idx;
                    op_d    = op_start_i[arb_idx];
                end
            end
            ST_RUN: begin
                if (exec_ready_i == TRUE) begin
                    state_d = ST_RELEASE;
                    done_d  = gnt_q;
                    ptr_d   = (sel_q == IDX_W'(NUM_REQ - 1)) ? '0 : sel_q + IDX_W'(1);
                end
            end
            // Hold the grant until the executor has visibly left its DONE state.
            ST_RELEASE: begin
                if (exec_ready_i == FALSE) begin
                    state_d = ST_IDLE;
                    gnt_d   = '0;
                end
            end
            ST_MOD: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: reset is synchronous here, so it lives inside the clocked branch only.
        if (rst) begin
            state_q <= ST_IDLE;
            gnt_q   <= '0;
            sel_q   <= '0;
            op_q    <= '0;
            ptr_q   <= '0;
            done_q  <= '0;
        end else begin
            // NOTE: non-blocking so every register updates from pre-edge values.
            state_q <= state_d;
            gnt_q   <= gnt_d;
            sel_q   <= sel_d;
            op_q    <= op_d;
            ptr_q   <= ptr_d;
            done_q  <= done_d;
        end
    end

    assign gnt_o            = gnt_q;
    assign sel_o            = sel_q;
    assign exec_op_start_o  = op_q;
    assign done_o           = done_q;
    assign exec_start_o     = (state_q == ST_RUN);
    assign exec_mod_start_o = (state_q == ST_MOD);
    assign mod_ack_o        = (state_q == ST_MOD);
    assign busy_o           = (state_q != ST_IDLE);

endmodule

// File: tb/tb_exec_sched.sv
// Directed self-checking bench for exec_sched with hand-computed expectations.
module tb_exec_sched;
    import exec_pkg::*;

    logic            clk = 1'b0;
    logic            rst;
    logic [3:0]      req_i;
    logic [3:0][7:0] op_start_i;
    logic [3:0]      gnt_o;
    logic [1:0]      sel_o;
    logic [3:0]      done_o;
    logic            exec_start_o;
    logic [7:0]      exec_op_start_o;
    logic            exec_ready_i;
    logic            mod_req_i;
    logic            mod_ack_o;
    logic            exec_mod_start_o;
    logic            busy_o;

    int errors = 0;
    int checks = 0;
    int done_cnt = 0;
    int cnt_before;

    exec_sched #(.NUM_REQ(4), .ADDR_W(8)) dut (
        .clk              (clk),
        .rst              (rst),
        .req_i            (req_i),
        .op_start_i       (op_start_i),
        .gnt_o            (gnt_o),
        .sel_o            (sel_o),
        .done_o           (done_o),
        .exec_start_o     (exec_start_o),
        .exec_op_start_o  (exec_op_start_o),
        .exec_ready_i     (exec_ready_i),
        .mod_req_i        (mod_req_i),
        .mod_ack_o        (mod_ack_o),
        .exec_mod_start_o (exec_mod_start_o),
        .busy_o           (busy_o)
    );

    always #5 clk = ~clk;

    // Counts done pulses and guards against mod_start overlapping a packet start.
    always @(negedge clk) begin
        done_cnt += $countones(done_o);
        if (exec_mod_start_o) begin
            checks++;
            assert (exec_start_o === 1'b0)
            else begin
                errors++;
                $error("FAIL mod_vs_start: observed start=%0b expected 0", exec_start_o);
            end
        end
    end

    task automatic step();
        @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    // Expects the grant on the next edge, raises ready lat cycles later, then lets it fall.
    task automatic serve(input int exp_sel, input logic [7:0] exp_op, input int lat,
                         input logic [3:0] req_after);
        step();
        check("gnt", gnt_o, 32'(1 << exp_sel));
        check("sel", sel_o, exp_sel);
        check("op_start", exec_op_start_o, exp_op);
        check("start", exec_start_o, 1);
        repeat (lat - 1) step();
        check("start_hold", exec_start_o, 1);
        exec_ready_i = 1'b1;
        step();
        check("done", done_o, 32'(1 << exp_sel));
        check("start_drop", exec_start_o, 0);
        check("gnt_hold", gnt_o, 32'(1 << exp_sel));
        exec_ready_i = 1'b0;
        req_i = req_after;
        step();
        check("gnt_clr", gnt_o, 0);
        check("done_once", done_o, 0);
    endtask

    initial begin
        rst          = 1'b0;
        req_i        = '0;
        mod_req_i    = 1'b0;
        exec_ready_i = 1'b0;
        op_start_i[0] = 8'd10;
        op_start_i[1] = 8'd5;
        op_start_i[2] = 8'd20;
        op_start_i[3] = 8'd30;
        step();
        do_reset();

        // Reset state
        check("rst_gnt", gnt_o, 0);
        check("rst_sel", sel_o, 0);
        check("rst_done", done_o, 0);
        check("rst_start", exec_start_o, 0);
        check("rst_op", exec_op_start_o, 0);
        check("rst_mod", exec_mod_start_o, 0);
        check("rst_ack", mod_ack_o, 0);
        check("rst_busy", busy_o, 0);
        check("rst_ptr", dut.ptr_q, 0);

        // Single requester, ready 6 cycles after start
        req_i = 4'b0010;
        serve(1, 8'd5, 6, 4'b0000);
        check("ptr_after_1", dut.ptr_q, 2);

        // Ready while idle is ignored
        exec_ready_i = 1'b1;
        step();
        step();
        check("idle_ready_done", done_o, 0);
        check("idle_ready_busy", busy_o, 0);
        exec_ready_i = 1'b0;

        // Round-robin fairness from ptr=0, all requests held
        do_reset();
        check("rst2_ptr", dut.ptr_q, 0);
        req_i = 4'b1111;
        cnt_before = done_cnt;
        serve(0, 8'd10, 3, 4'b1111);
        serve(1, 8'd5,  2, 4'b1111);
        serve(2, 8'd20, 4, 4'b1111);
        serve(3, 8'd30, 1, 4'b1111);
        check("rr_done_count", done_cnt - cnt_before, 4);
        serve(0, 8'd10, 2, 4'b0100);

        // Wrap-around: grant 2 leaves ptr=3, then 0101 gives 0 then 2
        serve(2, 8'd20, 2, 4'b0101);
        check("ptr_wrap", dut.ptr_q, 3);
        serve(0, 8'd10, 2, 4'b0101);
        serve(2, 8'd20, 2, 4'b0000);

        // Mod priority over a simultaneous packet request
        mod_req_i = 1'b1;
        req_i     = 4'b0100;
        step();
        check("mod_start", exec_mod_start_o, 1);
        check("mod_ack", mod_ack_o, 1);
        check("mod_busy", busy_o, 1);
        check("mod_no_gnt", gnt_o, 0);
        mod_req_i = 1'b0;
        step();
        check("mod_pulse_end", exec_mod_start_o, 0);
        check("mod_ack_end", mod_ack_o, 0);
        check("mod_gnt_wait", gnt_o, 0);
        check("mod_ptr_kept", dut.ptr_q, 3);
        serve(2, 8'd20, 3, 4'b0000);

        // Sticky ready: RELEASE for 3 cycles, request 3 waits
        req_i = 4'b0001;
        step();
        check("sticky_gnt", gnt_o, 4'b0001);
        step();
        exec_ready_i = 1'b1;
        step();
        check("sticky_done", done_o, 4'b0001);
        req_i = 4'b1000;
        for (int i = 0; i < 2; i++) begin
            step();
            check("sticky_release", dut.state_q, ST_RELEASE);
            check("sticky_no_start", exec_start_o, 0);
            check("sticky_gnt_hold", gnt_o, 4'b0001);
        end
        exec_ready_i = 1'b0;
        step();
        check("sticky_idle_gnt", gnt_o, 0);
        check("sticky_idle_start", exec_start_o, 0);
        step();
        check("next_gnt", gnt_o, 4'b1000);
        check("next_start", exec_start_o, 1);
        check("next_op", exec_op_start_o, 30);

        // Reset mid-RUN, two cycles after start
        step();
        step();
        rst   = 1'b1;
        req_i = 4'b0000;
        step();
        check("mid_rst_gnt", gnt_o, 0);
        check("mid_rst_start", exec_start_o, 0);
        check("mid_rst_done", done_o, 0);
        check("mid_rst_busy", busy_o, 0);
        check("mid_rst_sel", sel_o, 0);
        check("mid_rst_ptr", dut.ptr_q, 0);
        rst   = 1'b0;
        req_i = 4'b0001;
        serve(0, 8'd10, 3, 4'b0000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
